// File: rtl/apb_cfg_regs_if.sv
// APB bus bundle between the command decoder's APB master and the config register bank.
interface apb_cfg_regs_if;
    logic        psel;
    logic        penable;
    logic [15:0] paddr;
    logic [2:0]  pprot;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_cfg_regs.sv
// APB slave config/status register bank with programmable wait states, byte strobes,
// sticky error flags and slave-error responses for illegal accesses.
module apb_cfg_regs #(
    parameter logic [31:0] ID_VALUE    = 32'hEA00_0001,
    parameter int unsigned NUM_CFG     = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    apb_cfg_regs_if.slave          apb,
    input  logic                   stat_busy,
    input  logic                   stat_error,
    input  logic [3:0]             stat_fpga_index,
    input  logic [31:0]            stat_wreq_count,
    input  logic [31:0]            stat_rreq_count,
    input  logic [31:0]            stat_rack_count,
    output logic [32*NUM_CFG-1:0]  cfg_out
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [3:0] {
        R_ID, R_SCRATCH, R_STATUS, R_STICKY, R_WREQ, R_RREQ, R_RACK, R_CFG, R_BAD
    } reg_t;

    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state;
    logic [3:0]  wait_cnt;
    reg_t        sel_q;
    logic [5:0]  idx_q;
    logic        write_q;
    logic [3:0]  strb_q;
    logic [31:0] wdata_q;
    logic [31:0] scratch;
    logic [1:0]  sticky;
    logic        err_q;
    logic [31:0] cfg [NUM_CFG];

    reg_t        dec_sel;
    reg_t        cur_sel;
    logic [5:0]  cur_idx;
    logic        cur_write;
    logic [31:0] rd_val;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [1:0]  sticky_nxt;
    logic        unused_pprot;

    assign unused_pprot = ^apb.pprot;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wr,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int unsigned k = 0; k < 4; k++)
            if (strb[k]) r[8*k +: 8] = wr[8*k +: 8];
        return r;
    endfunction

    always_comb begin
        dec_sel = R_BAD;
        if (apb.paddr[1:0] == 2'b00) begin
            if (apb.paddr[15:8] == 8'h00) begin
                case (apb.paddr[7:2])
                    6'd0:    dec_sel = R_ID;
                    6'd1:    dec_sel = R_SCRATCH;
                    6'd2:    dec_sel = R_STATUS;
                    6'd3:    dec_sel = R_STICKY;
                    6'd4:    dec_sel = R_WREQ;
                    6'd5:    dec_sel = R_RREQ;
                    6'd6:    dec_sel = R_RACK;
                    default: dec_sel = R_BAD;
                endcase
            end else if (apb.paddr[15:8] == 8'h01 && 32'(apb.paddr[7:2]) < NUM_CFG) begin
                dec_sel = R_CFG;
            end
        end
    end

    // With zero wait states the response is built from the live decode, otherwise from the latch.
    always_comb begin
        cur_sel   = (state == S_IDLE) ? dec_sel : sel_q;
        cur_idx   = (state == S_IDLE) ? apb.paddr[7:2] : idx_q;
        cur_write = (state == S_IDLE) ? apb.pwrite : write_q;
        rd_val    = '0;
        case (cur_sel)
            R_ID:      rd_val = ID_VALUE;
            R_SCRATCH: rd_val = scratch;
            R_STATUS:  rd_val = {26'b0, stat_fpga_index, stat_error, stat_busy};
            R_STICKY:  rd_val = {30'b0, sticky};
            R_WREQ:    rd_val = stat_wreq_count;
            R_RREQ:    rd_val = stat_rreq_count;
            R_RACK:    rd_val = stat_rack_count;
            R_CFG:
                for (int unsigned i = 0; i < NUM_CFG; i++)
                    if (cur_idx == 6'(i)) rd_val = cfg[i];
            default:   rd_val = '0;
        endcase
        resp_err  = (cur_sel == R_BAD);
        resp_data = (cur_write || resp_err) ? '0 : rd_val;
    end

    // Clears are applied before sets so a coincident set survives.
    always_comb begin
        sticky_nxt = sticky;
        if (state == S_RESP && write_q && sel_q == R_STICKY && strb_q[0])
            sticky_nxt = sticky & ~wdata_q[1:0];
        if (stat_error && !err_q)
            sticky_nxt[0] = 1'b1;
        if (state == S_RESP && apb.pslverr)
            sticky_nxt[1] = 1'b1;
    end

    always_comb begin
        cfg_out = '0;
        for (int unsigned i = 0; i < NUM_CFG; i++)
            cfg_out[32*i +: 32] = cfg[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            apb.pready  <= 1'b0;
            apb.pslverr <= 1'b0;
            apb.prdata  <= '0;
            wait_cnt    <= '0;
            sel_q       <= R_BAD;
            idx_q       <= '0;
            write_q     <= 1'b0;
            strb_q      <= '0;
            wdata_q     <= '0;
            scratch     <= '0;
            sticky      <= '0;
            err_q       <= 1'b0;
            for (int unsigned i = 0; i < NUM_CFG; i++)
                cfg[i] <= '0;
        end else begin
            err_q  <= stat_error;
            sticky <= sticky_nxt;
            case (state)
                S_IDLE: begin
                    if (apb.psel && apb.penable) begin
                        sel_q    <= dec_sel;
                        idx_q    <= apb.paddr[7:2];
                        write_q  <= apb.pwrite;
                        strb_q   <= apb.pstrb;
                        wdata_q  <= apb.pwdata;
                        wait_cnt <= '0;
                        if (WAIT_CYCLES > 0) begin
                            state <= S_WAIT;
                        end else begin
                            state       <= S_RESP;
                            apb.pready  <= 1'b1;
                            apb.prdata  <= resp_data;
                            apb.pslverr <= resp_err;
                        end
                    end
                end
                S_WAIT: begin
                    if (!apb.psel) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= S_RESP;
                        apb.pready  <= 1'b1;
                        apb.prdata  <= resp_data;
                        apb.pslverr <= resp_err;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    state       <= S_IDLE;
                    apb.pready  <= 1'b0;
                    apb.pslverr <= 1'b0;
                    apb.prdata  <= '0;
                    if (write_q) begin
                        case (sel_q)
                            R_SCRATCH: scratch <= merge(scratch, wdata_q, strb_q);
                            R_CFG:
                                for (int unsigned i = 0; i < NUM_CFG; i++)
                                    if (idx_q == 6'(i)) cfg[i] <= merge(cfg[i], wdata_q, strb_q);
                            default: ;
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cfg_regs.sv
// Randomized + directed scoreboard bench for apb_cfg_regs against an address-map model.
module tb_apb_cfg_regs;
    localparam int unsigned NCFG  = 8;
    localparam int unsigned NWAIT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        stat_busy = 1'b0;
    logic        stat_error = 1'b0;
    logic [3:0]  stat_fpga_index = '0;
    logic [31:0] stat_wreq_count = '0;
    logic [31:0] stat_rreq_count = '0;
    logic [31:0] stat_rack_count = '0;
    logic [32*NCFG-1:0] cfg_out;

    apb_cfg_regs_if bus();

    apb_cfg_regs #(
        .ID_VALUE(32'hEA00_0001),
        .NUM_CFG(NCFG),
        .WAIT_CYCLES(NWAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .apb(bus),
        .stat_busy(stat_busy),
        .stat_error(stat_error),
        .stat_fpga_index(stat_fpga_index),
        .stat_wreq_count(stat_wreq_count),
        .stat_rreq_count(stat_rreq_count),
        .stat_rack_count(stat_rack_count),
        .cfg_out(cfg_out)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_cfg [NCFG];
    logic [31:0] m_scratch;
    logic [1:0]  m_sticky;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [15:0] a);
        if (a[1:0] != 2'b00) return 1'b0;
        if (a <= 16'h0018) return 1'b1;
        return (a >= 16'h0100) && (32'(a) < 32'h100 + 4 * NCFG);
    endfunction

    function automatic logic [31:0] mval(input logic [15:0] a);
        case (a)
            16'h0000: return 32'hEA00_0001;
            16'h0004: return m_scratch;
            16'h0008: return {26'b0, stat_fpga_index, stat_error, stat_busy};
            16'h000C: return {30'b0, m_sticky};
            16'h0010: return stat_wreq_count;
            16'h0014: return stat_rreq_count;
            16'h0018: return stat_rack_count;
            default:  return m_cfg[(32'(a) - 32'h100) / 4];
        endcase
    endfunction

    function automatic logic [31:0] bytes(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (s[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCFG; i++) m_cfg[i] = '0;
        m_scratch = '0;
        m_sticky  = '0;
    endtask

    // Predicts the response, pushes it, then applies the transfer's side effects to the model.
    task automatic model_xfer(input logic [15:0] a, input logic w, input logic [3:0] s,
                              input logic [31:0] d, input bit pulse);
        resp_t r;
        bit ok;
        ok     = legal(a);
        r.err  = !ok;
        r.data = (w || !ok) ? 32'h0 : mval(a);
        exp_q.push_back(r);
        if (ok && w) begin
            if (a == 16'h0004) m_scratch = bytes(m_scratch, d, s);
            else if (a == 16'h000C && s[0]) m_sticky = m_sticky & ~d[1:0];
            else if (a >= 16'h0100) m_cfg[(32'(a) - 32'h100) / 4] = bytes(m_cfg[(32'(a) - 32'h100) / 4], d, s);
        end
        if (!ok) m_sticky[1] = 1'b1;
        if (pulse) m_sticky[0] = 1'b1;
    endtask

    // Returns while still in the response cycle, with psel already dropped.
    task automatic xfer(input logic [15:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] d, input bit pulse);
        int cyc;
        model_xfer(a, w, s, d, pulse);
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b1; bus.paddr = a; bus.pwrite = w;
        bus.pstrb = s; bus.pwdata = d; bus.pprot = 3'($urandom_range(0, 7));
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (bus.pready !== 1'b1 && cyc < 20);
        if (bus.pready !== 1'b1) begin
            total++; bad++;
            $display("FAIL timeout: no pready for addr %h after %0d cycles", a, cyc);
            void'(exp_q.pop_back());
        end else begin
            check("latency", 32'(cyc), 32'(NWAIT + 1));
        end
        if (pulse) stat_error = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.pready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_pready: got pready=1 expected no response");
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                check("prdata", bus.prdata, e.data);
                check("pslverr", 32'(bus.pslverr), 32'(e.err));
            end
        end
    end

    initial begin
        bit saw;
        int guard;
        logic [15:0] a;
        logic [15:0] bad_addr [5];
        bad_addr[0] = 16'h0200; bad_addr[1] = 16'h0120; bad_addr[2] = 16'h001C;
        bad_addr[3] = 16'h0102; bad_addr[4] = 16'h0002;

        bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = '0; bus.pprot = '0;
        bus.pwrite = 1'b0; bus.pstrb = '0; bus.pwdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_pready", 32'(bus.pready), 32'h0);
        check("rst_prdata", bus.prdata, 32'h0);
        check("rst_pslverr", 32'(bus.pslverr), 32'h0);
        check("rst_cfg", 32'(|cfg_out), 32'h0);

        xfer(16'h0000, 1'b0, 4'h0, 32'h0, 1'b0);

        xfer(16'h0104, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0);
        xfer(16'h0104, 1'b1, 4'b0101, 32'h1234_5678, 1'b0);
        check("cfg1_before_commit", cfg_out[63:32], 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("cfg1_after_commit", cfg_out[63:32], 32'hFF34_FF78);
        xfer(16'h0104, 1'b0, 4'h0, 32'h0, 1'b0);

        xfer(16'h0200, 1'b0, 4'h0, 32'h0, 1'b0);
        xfer(16'h0002, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0);
        xfer(16'h0004, 1'b0, 4'h0, 32'h0, 1'b0);
        xfer(16'h000C, 1'b0, 4'h0, 32'h0, 1'b0);
        xfer(16'h000C, 1'b1, 4'hF, 32'h2, 1'b0);
        xfer(16'h000C, 1'b0, 4'h0, 32'h0, 1'b0);

        stat_wreq_count = 32'd7; stat_busy = 1'b1; stat_fpga_index = 4'd5;
        xfer(16'h0010, 1'b0, 4'h0, 32'h0, 1'b0);
        xfer(16'h0008, 1'b0, 4'h0, 32'h0, 1'b0);
        xfer(16'h0010, 1'b1, 4'hF, 32'h0000_BEEF, 1'b0);
        xfer(16'h0010, 1'b0, 4'h0, 32'h0, 1'b0);
        stat_busy = 1'b0;

        // Raise bit0, clear it with W1C, then clear again while a new rise lands on the commit edge.
        stat_error = 1'b1; m_sticky[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 stat_error = 1'b0;
        repeat (2) @(posedge clk);
        xfer(16'h000C, 1'b0, 4'h0, 32'h0, 1'b0);
        xfer(16'h000C, 1'b1, 4'h1, 32'h1, 1'b0);
        xfer(16'h000C, 1'b0, 4'h0, 32'h0, 1'b0);
        xfer(16'h000C, 1'b1, 4'h1, 32'h1, 1'b1);
        repeat (2) @(posedge clk);
        #1 stat_error = 1'b0;
        xfer(16'h000C, 1'b0, 4'h0, 32'h0, 1'b0);

        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b1; bus.paddr = 16'h0100; bus.pwrite = 1'b1;
        bus.pstrb = 4'hF; bus.pwdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
        model_reset();
        saw = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.pready === 1'b1) saw = 1'b1;
        end
        check("rst_wait_pready", 32'(saw), 32'h0);
        check("rst_wait_cfg0", cfg_out[31:0], 32'h0);

        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b1; bus.paddr = 16'h0108; bus.pwrite = 1'b1;
        bus.pstrb = 4'hF; bus.pwdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        saw = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.pready === 1'b1) saw = 1'b1;
        end
        check("abort_pready", 32'(saw), 32'h0);
        check("abort_cfg2", cfg_out[95:64], 32'h0);
        xfer(16'h0108, 1'b0, 4'h0, 32'h0, 1'b0);
        xfer(16'h000C, 1'b0, 4'h0, 32'h0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            int r;
            stat_busy       = 1'($urandom_range(0, 1));
            stat_fpga_index = 4'($urandom_range(0, 15));
            stat_wreq_count = $urandom();
            stat_rreq_count = $urandom();
            stat_rack_count = $urandom();
            r = $urandom_range(0, 9);
            if (r <= 6) a = 16'(4 * r);
            else if (r == 8) a = bad_addr[$urandom_range(0, 4)];
            else a = 16'(32'h100 + 4 * $urandom_range(0, NCFG - 1));
            xfer(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        @(posedge clk); #1;
        for (int i = 0; i < NCFG; i++)
            check("cfg_final", cfg_out[32*i +: 32], m_cfg[i]);

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
